// File: rtl/noc_port_request_control.sv
// noc_port_request_control
// Upstream half of the output-port control handshake for one router input
// port. Every virtual channel runs its own small FSM: a valid header claims
// one of the five output ports, body flits are requested one per cycle, a
// grant pops the VC buffer, and the tail transfer releases the port again.
// Headers naming a port above 4 are drained silently and flagged on drop_err.
module noc_port_request_control #(
  parameter int CHANNELS    = 2,
  parameter int STALL_LIMIT = 255
) (
  input  logic                     noc_clk,
  input  logic                     noc_rst,
  input  logic [CHANNELS-1:0]      flit_valid,
  input  logic [CHANNELS-1:0]      flit_head,
  input  logic [CHANNELS-1:0]      flit_tail,
  input  logic [CHANNELS-1:0][2:0] flit_dest,
  output logic [CHANNELS-1:0]      flit_pop,
  output logic [4:0][CHANNELS-1:0] start_of_packet,
  output logic [4:0][CHANNELS-1:0] request,
  input  logic [4:0][CHANNELS-1:0] grant,
  output logic [4:0][CHANNELS-1:0] free,
  output logic [4:0][CHANNELS-1:0] end_of_packet,
  output logic [CHANNELS-1:0]      drop_err,
  output logic [CHANNELS-1:0]      stall
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_DROP   = 2'd2;

  localparam logic [15:0] STALL_THRESH = 16'(STALL_LIMIT);
  localparam logic [15:0] CNT_MAX      = 16'hFFFF;

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_vc
    logic [1:0]  state_q, state_d;
    logic [2:0]  dest_q, dest_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [4:0]  sop_q, sop_d;
    logic        drop_q, drop_d;
    logic        stall_q, stall_d;
    logic [4:0]  dest_oh;
    logic [4:0]  grant_col;
    logic        req, pop, rel;

    // Fan the per-VC column in and out of the [port][vc] matrices. The
    // combinational outputs are forced low while reset is held so that a
    // flit sitting in the buffer is never popped during reset.
    for (genvar ri = 0; ri < 5; ri++) begin : g_row
      assign grant_col[ri]             = grant[ri][gi];
      assign start_of_packet[ri][gi]   = sop_q[ri];
      assign request[ri][gi]           = dest_oh[ri] & req & ~noc_rst;
      assign free[ri][gi]              = dest_oh[ri] & rel & ~noc_rst;
      assign end_of_packet[ri][gi]     = dest_oh[ri] & rel & ~noc_rst;
    end

    assign flit_pop[gi] = pop & ~noc_rst;
    assign drop_err[gi] = drop_q;
    assign stall[gi]    = stall_q;

    // One-hot decode of the claimed output port.
    always_comb begin
      dest_oh = '0;
      for (int r = 0; r < 5; r++) begin
        dest_oh[r] = (dest_q == 3'(r));
      end
    end

    // Per-VC protocol: claim, request/pop, release, and drop handling.
    always_comb begin
      state_d     = state_q;
      dest_d      = dest_q;
      stall_cnt_d = stall_cnt_q;
      drop_d      = 1'b0;
      req         = 1'b0;
      pop         = 1'b0;
      rel         = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (flit_valid[gi]) begin
            if (flit_head[gi]) begin
              if (flit_dest[gi] <= 3'd4) begin
                // Header stays in the buffer; it is popped once granted.
                dest_d  = flit_dest[gi];
                state_d = ST_ACTIVE;
              end else begin
                state_d = ST_DROP;
                drop_d  = 1'b1;
              end
            end else begin
              // Body flit without a header: discard it on the spot.
              pop    = 1'b1;
              drop_d = 1'b1;
            end
          end
        end
        ST_ACTIVE: begin
          req = flit_valid[gi];
          pop = req & |(grant_col & dest_oh);
          if (pop) begin
            stall_cnt_d = '0;
            if (flit_tail[gi]) begin
              rel     = 1'b1;
              state_d = ST_IDLE;
            end
          end else if (req && stall_cnt_q != CNT_MAX) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
          end
        end
        ST_DROP: begin
          pop = flit_valid[gi];
          if (flit_valid[gi] && flit_tail[gi]) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Registered outputs follow the next state so they line up with it.
    always_comb begin
      sop_d = '0;
      if (state_d == ST_ACTIVE) begin
        for (int r = 0; r < 5; r++) begin
          sop_d[r] = (dest_d == 3'(r));
        end
      end
      stall_d = (stall_cnt_d >= STALL_THRESH);
    end

    // State and registered outputs, cleared asynchronously by reset.
    always_ff @(posedge noc_clk or posedge noc_rst) begin
      if (noc_rst) begin
        state_q     <= ST_IDLE;
        dest_q      <= '0;
        stall_cnt_q <= '0;
        sop_q       <= '0;
        drop_q      <= 1'b0;
        stall_q     <= 1'b0;
      end else begin
        state_q     <= state_d;
        dest_q      <= dest_d;
        stall_cnt_q <= stall_cnt_d;
        sop_q       <= sop_d;
        drop_q      <= drop_d;
        stall_q     <= stall_d;
      end
    end
  end

endmodule

// File: tb/tb_noc_port_request_control.sv
// Testbench for noc_port_request_control (2 VCs, stall limit 3).
// Directed cycle table, a hand-written async reset sequence, then random
// traffic compared against a packet-level reference model.
module tb_noc_port_request_control;

  localparam int CH      = 2;
  localparam int LIMIT   = 3;
  localparam int FREE    = -1;
  localparam int DISCARD = 8;

  logic                   noc_clk = 1'b0;
  logic                   noc_rst;
  logic [CH-1:0]          flit_valid, flit_head, flit_tail, flit_pop, drop_err, stall;
  logic [CH-1:0][2:0]     flit_dest;
  logic [4:0][CH-1:0]     start_of_packet, request, grant, free, end_of_packet;

  int checks   = 0;
  int failures = 0;

  always #5 noc_clk = ~noc_clk;

  noc_port_request_control #(.CHANNELS(CH), .STALL_LIMIT(LIMIT)) dut (
    .noc_clk         (noc_clk),
    .noc_rst         (noc_rst),
    .flit_valid      (flit_valid),
    .flit_head       (flit_head),
    .flit_tail       (flit_tail),
    .flit_dest       (flit_dest),
    .flit_pop        (flit_pop),
    .start_of_packet (start_of_packet),
    .request         (request),
    .grant           (grant),
    .free            (free),
    .end_of_packet   (end_of_packet),
    .drop_err        (drop_err),
    .stall           (stall)
  );

  typedef struct {
    logic [1:0] v, h, t;
    logic [5:0] d;
    logic [9:0] g;
    logic [1:0] pop;
    logic [9:0] sop, req, fr, eop;
    logic [1:0] drp, stl;
  } vec_t;

  typedef struct {
    bit       h, t;
    bit [2:0] d;
  } flit_t;

  vec_t  tbl[$];
  flit_t fq[CH][$];

  task automatic add(input logic [1:0] v, h, t, input logic [5:0] d, input logic [9:0] g,
                     input logic [1:0] pop, input logic [9:0] sop, req, fr, eop,
                     input logic [1:0] drp, stl);
    vec_t r;
    r.v = v; r.h = h; r.t = t; r.d = d; r.g = g;
    r.pop = pop; r.sop = sop; r.req = req; r.fr = fr; r.eop = eop;
    r.drp = drp; r.stl = stl;
    tbl.push_back(r);
  endtask

  task automatic drive(input logic [1:0] v, h, t, input logic [5:0] d, input logic [9:0] g);
    flit_valid = v; flit_head = h; flit_tail = t; flit_dest = d; grant = g;
  endtask

  task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] pop, input logic [9:0] sop, req, fr, eop,
                         input logic [1:0] drp, stl);
    chk({tag, " pop"},   10'(flit_pop), 10'(pop));
    chk({tag, " sop"},   start_of_packet, sop);
    chk({tag, " req"},   request, req);
    chk({tag, " free"},  free, fr);
    chk({tag, " eop"},   end_of_packet, eop);
    chk({tag, " drop"},  10'(drop_err), 10'(drp));
    chk({tag, " stall"}, 10'(stall), 10'(stl));
  endtask

  // Queue one packet (or a stray body flit) into a VC's buffer.
  task automatic gen_packet(input int vc);
    flit_t f;
    int r, len, dst;
    r = int'($urandom_range(0, 9));
    if (r == 0) begin
      f.h = 1'b0; f.t = 1'($urandom_range(0, 1)); f.d = 3'($urandom_range(0, 7));
      fq[vc].push_back(f);
    end else begin
      len = int'($urandom_range(1, 4));
      dst = (r == 1) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, 4));
      for (int i = 0; i < len; i++) begin
        f.h = (i == 0);
        f.t = (i == len - 1);
        f.d = (i == 0) ? 3'(dst) : 3'($urandom_range(0, 7));
        fq[vc].push_back(f);
      end
    end
  endtask

  // Reference model state: claimed port per VC (FREE, 0..4, DISCARD).
  int         claim[CH];
  int         scnt[CH];
  bit         pend[CH];
  logic [1:0] rv, rh, rt, e_pop, e_drp, e_stl;
  logic [5:0] rd;
  logic [9:0] rg, e_sop, e_req, e_fr, e_eop;

  initial begin
    // Reset state, with non-head flits offered that must not be popped.
    noc_rst = 1'b1;
    drive(2'b11, 2'b00, 2'b00, 6'h00, 10'h3ff);
    #7;
    chk_all("reset", 2'b00, 10'h0, 10'h0, 10'h0, 10'h0, 2'b00, 2'b00);
    @(negedge noc_clk);
    drive(2'b00, 2'b00, 2'b00, 6'h00, 10'h000);
    noc_rst = 1'b0;

    //   v      h      t      d      g       pop    sop     req     free    eop     drop   stall
    // Single-flit packet, VC0 -> port 2, grant follows request.
    add(2'b01, 2'b01, 2'b01, 6'h02, 10'h000, 2'b00, 10'h000, 10'h000, 10'h000, 10'h000, 2'b00, 2'b00);
    add(2'b01, 2'b01, 2'b01, 6'h02, 10'h010, 2'b01, 10'h010, 10'h010, 10'h010, 10'h010, 2'b00, 2'b00);
    add(2'b00, 2'b00, 2'b00, 6'h00, 10'h000, 2'b00, 10'h000, 10'h000, 10'h000, 10'h000, 2'b00, 2'b00);
    // 4-flit packet, VC1 -> port 4, grant withheld for 3 cycles.
    add(2'b10, 2'b10, 2'b00, 6'h20, 10'h000, 2'b00, 10'h000, 10'h000, 10'h000, 10'h000, 2'b00, 2'b00);
    add(2'b10, 2'b10, 2'b00, 6'h20, 10'h000, 2'b00, 10'h200, 10'h200, 10'h000, 10'h000, 2'b00, 2'b00);
    add(2'b10, 2'b10, 2'b00, 6'h20, 10'h000, 2'b00, 10'h200, 10'h200, 10'h000, 10'h000, 2'b00, 2'b00);
    add(2'b10, 2'b10, 2'b00, 6'h20, 10'h000, 2'b00, 10'h200, 10'h200, 10'h000, 10'h000, 2'b00, 2'b00);
    add(2'b10, 2'b10, 2'b00, 6'h20, 10'h200, 2'b10, 10'h200, 10'h200, 10'h000, 10'h000, 2'b00, 2'b10);
    add(2'b10, 2'b00, 2'b00, 6'h20, 10'h200, 2'b10, 10'h200, 10'h200, 10'h000, 10'h000, 2'b00, 2'b00);
    add(2'b10, 2'b00, 2'b00, 6'h20, 10'h200, 2'b10, 10'h200, 10'h200, 10'h000, 10'h000, 2'b00, 2'b00);
    add(2'b10, 2'b00, 2'b10, 6'h20, 10'h200, 2'b10, 10'h200, 10'h200, 10'h200, 10'h200, 2'b00, 2'b00);
    add(2'b00, 2'b00, 2'b00, 6'h00, 10'h000, 2'b00, 10'h000, 10'h000, 10'h000, 10'h000, 2'b00, 2'b00);
    // Header with dest 6 plus two flits on VC0: drained, never requested.
    add(2'b01, 2'b01, 2'b00, 6'h06, 10'h000, 2'b00, 10'h000, 10'h000, 10'h000, 10'h000, 2'b00, 2'b00);
    add(2'b01, 2'b01, 2'b00, 6'h06, 10'h3ff, 2'b01, 10'h000, 10'h000, 10'h000, 10'h000, 2'b01, 2'b00);
    add(2'b01, 2'b00, 2'b00, 6'h06, 10'h3ff, 2'b01, 10'h000, 10'h000, 10'h000, 10'h000, 2'b00, 2'b00);
    add(2'b01, 2'b00, 2'b01, 6'h06, 10'h3ff, 2'b01, 10'h000, 10'h000, 10'h000, 10'h000, 2'b00, 2'b00);
    add(2'b00, 2'b00, 2'b00, 6'h00, 10'h000, 2'b00, 10'h000, 10'h000, 10'h000, 10'h000, 2'b00, 2'b00);
    // Body flit arriving in IDLE on VC1.
    add(2'b10, 2'b00, 2'b00, 6'h00, 10'h3ff, 2'b10, 10'h000, 10'h000, 10'h000, 10'h000, 2'b00, 2'b00);
    add(2'b00, 2'b00, 2'b00, 6'h00, 10'h000, 2'b00, 10'h000, 10'h000, 10'h000, 10'h000, 2'b10, 2'b00);
    add(2'b00, 2'b00, 2'b00, 6'h00, 10'h000, 2'b00, 10'h000, 10'h000, 10'h000, 10'h000, 2'b00, 2'b00);
    // Both VCs claim port 0, grants alternate between them.
    add(2'b11, 2'b11, 2'b00, 6'h00, 10'h000, 2'b00, 10'h000, 10'h000, 10'h000, 10'h000, 2'b00, 2'b00);
    add(2'b11, 2'b11, 2'b00, 6'h00, 10'h001, 2'b01, 10'h003, 10'h003, 10'h000, 10'h000, 2'b00, 2'b00);
    add(2'b11, 2'b10, 2'b01, 6'h00, 10'h002, 2'b10, 10'h003, 10'h003, 10'h000, 10'h000, 2'b00, 2'b00);
    add(2'b11, 2'b00, 2'b11, 6'h00, 10'h001, 2'b01, 10'h003, 10'h003, 10'h001, 10'h001, 2'b00, 2'b00);
    add(2'b10, 2'b00, 2'b10, 6'h00, 10'h002, 2'b10, 10'h002, 10'h002, 10'h002, 10'h002, 2'b00, 2'b00);
    add(2'b00, 2'b00, 2'b00, 6'h00, 10'h000, 2'b00, 10'h000, 10'h000, 10'h000, 10'h000, 2'b00, 2'b00);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge noc_clk);
      drive(tbl[i].v, tbl[i].h, tbl[i].t, tbl[i].d, tbl[i].g);
      #2;
      chk_all($sformatf("row%0d", i), tbl[i].pop, tbl[i].sop, tbl[i].req, tbl[i].fr,
              tbl[i].eop, tbl[i].drp, tbl[i].stl);
      $display("row %0d v=%b h=%b t=%b g=%h pop=%b sop=%h req=%h free=%h drop=%b stall=%b",
               i, tbl[i].v, tbl[i].h, tbl[i].t, tbl[i].g, flit_pop, start_of_packet,
               request, free, drop_err, stall);
    end

    // Async reset on the 2nd flit of a 3-flit packet (VC0 -> port 1).
    @(negedge noc_clk);
    drive(2'b01, 2'b01, 2'b00, 6'h01, 10'h000); #2;
    chk_all("rst_hdr", 2'b00, 10'h000, 10'h000, 10'h000, 10'h000, 2'b00, 2'b00);
    @(negedge noc_clk);
    drive(2'b01, 2'b01, 2'b00, 6'h01, 10'h004); #2;
    chk_all("rst_f1", 2'b01, 10'h004, 10'h004, 10'h000, 10'h000, 2'b00, 2'b00);
    @(negedge noc_clk);
    drive(2'b01, 2'b00, 2'b00, 6'h01, 10'h004); #2;
    chk_all("rst_f2", 2'b01, 10'h004, 10'h004, 10'h000, 10'h000, 2'b00, 2'b00);
    noc_rst = 1'b1; #1;
    chk_all("rst_async", 2'b00, 10'h000, 10'h000, 10'h000, 10'h000, 2'b00, 2'b00);
    $display("reset asserted mid-packet pop=%b sop=%h req=%h", flit_pop, start_of_packet, request);
    @(negedge noc_clk);
    noc_rst = 1'b0;
    drive(2'b00, 2'b00, 2'b00, 6'h00, 10'h000); #2;
    chk_all("rst_rel", 2'b00, 10'h000, 10'h000, 10'h000, 10'h000, 2'b00, 2'b00);
    @(negedge noc_clk);
    drive(2'b01, 2'b01, 2'b01, 6'h03, 10'h000); #2;
    chk_all("rst_new0", 2'b00, 10'h000, 10'h000, 10'h000, 10'h000, 2'b00, 2'b00);
    @(negedge noc_clk);
    drive(2'b01, 2'b01, 2'b01, 6'h03, 10'h040); #2;
    chk_all("rst_new1", 2'b01, 10'h040, 10'h040, 10'h040, 10'h040, 2'b00, 2'b00);
    $display("post-reset packet pop=%b sop=%h free=%h", flit_pop, start_of_packet, free);
    @(negedge noc_clk);
    drive(2'b00, 2'b00, 2'b00, 6'h00, 10'h000); #2;
    chk_all("rst_new2", 2'b00, 10'h000, 10'h000, 10'h000, 10'h000, 2'b00, 2'b00);

    // Random traffic against the packet-level model.
    for (int vc = 0; vc < CH; vc++) begin
      claim[vc] = FREE; scnt[vc] = 0; pend[vc] = 1'b0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge noc_clk);
      for (int vc = 0; vc < CH; vc++) begin
        if (fq[vc].size() == 0) gen_packet(vc);
        rv[vc] = ($urandom_range(0, 3) != 0);
        rh[vc] = fq[vc][0].h;
        rt[vc] = fq[vc][0].t;
        rd[vc*3 +: 3] = fq[vc][0].d;
      end
      rg = 10'($urandom);
      drive(rv, rh, rt, rd, rg);
      #2;
      e_pop = '0; e_sop = '0; e_req = '0; e_fr = '0; e_eop = '0;
      for (int vc = 0; vc < CH; vc++) begin
        e_drp[vc] = pend[vc];
        e_stl[vc] = (scnt[vc] >= LIMIT);
        if (claim[vc] == FREE) begin
          e_pop[vc] = rv[vc] & ~rh[vc];
        end else if (claim[vc] == DISCARD) begin
          e_pop[vc] = rv[vc];
        end else begin
          e_sop[claim[vc]*CH + vc] = 1'b1;
          e_req[claim[vc]*CH + vc] = rv[vc];
          e_pop[vc] = rv[vc] & rg[claim[vc]*CH + vc];
          e_fr[claim[vc]*CH + vc]  = e_pop[vc] & rt[vc];
          e_eop[claim[vc]*CH + vc] = e_pop[vc] & rt[vc];
        end
      end
      chk_all($sformatf("rnd%0d", cyc), e_pop, e_sop, e_req, e_fr, e_eop, e_drp, e_stl);
      // Advance the model by one cycle.
      for (int vc = 0; vc < CH; vc++) begin
        pend[vc] = 1'b0;
        if (claim[vc] == FREE) begin
          if (rv[vc] && !rh[vc]) pend[vc] = 1'b1;
          if (rv[vc] && rh[vc]) begin
            if (int'(rd[vc*3 +: 3]) <= 4) claim[vc] = int'(rd[vc*3 +: 3]);
            else begin claim[vc] = DISCARD; pend[vc] = 1'b1; end
          end
        end else if (claim[vc] == DISCARD) begin
          if (rv[vc] && rt[vc]) claim[vc] = FREE;
        end else begin
          if (e_pop[vc]) begin
            scnt[vc] = 0;
            if (rt[vc]) claim[vc] = FREE;
          end else if (rv[vc] && scnt[vc] < 65535) begin
            scnt[vc]++;
          end
        end
        if (e_pop[vc]) void'(fq[vc].pop_front());
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/noc_port_request_control.md
# noc_port_request_control

Per-input-port requester that drives the output-port control protocol from the upstream side. It sits behind each router input port's virtual-channel (VC) buffers and turns packet head flits into per-VC claims on one of the five output ports (local plus four directions). It then issues per-flit requests, consumes grants by popping the VC buffer, and releases the output on the tail flit. It is the counterpart of each output port's arbitration and grant logic.

## Interface
- CHANNELS, default Noc_VC_Channel: number of VCs per input port (≥1).
- STALL_LIMIT, default 255: count of consecutive ungranted request cycles after which a VC flags a stall (1..65535).
- noc_clk  in  1  clock.
- noc_rst  in  1  reset. One clock; reset is asynchronous and active-high.
- flit_valid  in  [CHANNELS]  VC buffer head flit present.
- flit_head  in  [CHANNELS]  head flit is a packet header.
- flit_tail  in  [CHANNELS]  head flit is the last flit of its packet. Head and tail together mean a single-flit packet.
- flit_dest  in  [CHANNELS][3]  output port index carried by the header (0..4). Sampled only on head flits.
- flit_pop  out  [CHANNELS]  pop the VC buffer; the flit is transferred this cycle.
- start_of_packet  out  [5][CHANNELS]  port claim, held for the whole packet.
- request  out  [5][CHANNELS]  per-flit transfer request.
- grant  in  [5][CHANNELS]  per-flit grant from the output port controller.
- free  out  [5][CHANNELS]  one-cycle VC release, asserted with the tail transfer.
- end_of_packet  out  [5][CHANNELS]  one-cycle port release, asserted with the tail transfer.
- drop_err  out  [CHANNELS]  one-cycle pulse when a header with dest > 4 is discarded.
- stall  out  [CHANNELS]  level; the stall counter has reached STALL_LIMIT.

## Operation
- One independent FSM per VC, with states IDLE, ACTIVE and DROP. Each FSM has a registered `dest` (3 bits) and a `stall_cnt` (16 bits, saturating).
- **IDLE**
  - All outputs for the VC are 0.
  - flit_valid & flit_head & dest ≤ 4: latch dest and go to ACTIVE. The flit is not popped in IDLE.
  - flit_valid & flit_head & dest > 4: go to DROP and pulse drop_err on the next cycle.
  - flit_valid & !flit_head: protocol violation. Pop the flit, stay in IDLE, pulse drop_err.
- **ACTIVE** (all outputs on row `dest` only; every other row is 0)
  - start_of_packet = 1.
  - request = flit_valid.
  - flit_pop = request & grant[dest].
  - On a pop with flit_tail = 1: free = 1 and end_of_packet = 1 in the same cycle, then go to IDLE.
  - A pop with flit_tail = 0: stay in ACTIVE.
  - grant is ignored while request = 0, and grant on any other row is ignored.
- **DROP**
  - flit_pop = flit_valid. No request is issued.
  - Leave for IDLE after a popped tail flit.
- **Stall counter**
  - Increments on each ACTIVE cycle with request & !grant[dest]. Saturates at 65535.
  - Clears on any pop and on any exit from ACTIVE.
  - stall = (stall_cnt ≥ STALL_LIMIT), registered.
- VCs never interact. Several VCs may target the same port simultaneously; arbitration belongs to the output side.

## Timing
- Reset (asynchronous, while noc_rst = 1):
  - all FSMs go to IDLE and stall_cnt = 0;
  - flit_pop, start_of_packet, request, free, end_of_packet, drop_err and stall are all 0.
- Reset mid-packet abandons the packet. The buffer is not popped further, and the downstream side is released by its own reset.
- Registered outputs: start_of_packet, drop_err, stall.
- Combinational outputs: request, flit_pop, free, end_of_packet. These depend on registered state plus flit_valid, flit_tail and grant; there is no path from any flit_* input to start_of_packet.
- Header at cycle 0 (IDLE) → start_of_packet and request at cycle 1. A same-cycle grant at cycle 1 pops the header at cycle 1.
- Minimum packet length N flits with continuous grant: IDLE→IDLE takes N+1 cycles.
- A new header can be accepted in the cycle after the tail pop. Back-to-back packets therefore have a one-cycle IDLE bubble.
- A single-flit packet pops with free and end_of_packet together in the first ACTIVE cycle that has a grant.
- flit_valid dropping mid-packet: request deasserts while start_of_packet stays high, and the stall counter does not count.

## Test plan
- Single-flit packet, VC0, dest=2, grant tied to request → cycle 1: start_of_packet[2][0], request, grant, pop, free and end_of_packet all 1; cycle 2: all 0.
- 4-flit packet, VC1, dest=4, grant withheld for 3 cycles then continuous → 4 pops; free and end_of_packet only on the 4th pop; stall=1 only when STALL_LIMIT ≤ 3.
- Both VCs with dest=0 in the same cycle, grant alternating between VCs → each VC pops only on its own grant; no cross-VC pops; each VC's release appears on its own column.
- Header with dest=6 followed by 2 more flits → drop_err pulses once; 3 pops; request and start_of_packet stay 0.
- Async reset asserted on the 2nd flit of a 3-flit packet → all outputs 0 immediately; after release the FSM is IDLE; the next header is treated as a new packet.
- Non-head flit arriving in IDLE → popped; drop_err pulses once; no request is raised.
